// File: rtl/gadget_pkg.sv
// ============================================================================
// Module   : gadget_pkg
// Purpose  : Item codes and classification helpers for the power-up manager.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gadget_pkg;

    localparam int CODE_W = 3;

    typedef enum logic [CODE_W-1:0] {
        ITEM_EMPTY         = 3'd0,
        ITEM_LOTION        = 3'd1,
        ITEM_ADD_BOMB      = 3'd2,
        ITEM_SKULL         = 3'd3,
        ITEM_HIDE_LOTION   = 3'd4,
        ITEM_HIDE_ADD_BOMB = 3'd5,
        ITEM_HIDE_SKULL    = 3'd6,
        ITEM_RSVD          = 3'd7
    } item_e;

    function automatic logic is_hidden(input logic [CODE_W-1:0] code);
        return (code >= 3'd4) && (code <= 3'd6);
    endfunction

    function automatic logic is_visible(input logic [CODE_W-1:0] code);
        return (code >= 3'd1) && (code <= 3'd3);
    endfunction

    // Hidden codes map to their visible counterpart; everything else passes through.
    function automatic logic [CODE_W-1:0] reveal(input logic [CODE_W-1:0] code);
        return is_hidden(code) ? (code - 3'd3) : code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gadget_cell.sv
// ============================================================================
// Module   : gadget_cell
// Purpose  : One map cell: item register, flame edge detect, lifetime counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gadget_cell
    import gadget_pkg::*;
#(
    parameter int LIFETIME = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_explode,
    input  logic              i_tick,
    input  logic              i_taken,
    input  logic              i_init_we,
    input  logic [CODE_W-1:0] i_init_item,
    output logic [CODE_W-1:0] o_item
);

    localparam int CNT_W = $clog2(LIFETIME + 1);

    logic [CODE_W-1:0] r_item;
    logic              r_explode_q;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_rise;

    assign w_rise = i_explode & ~r_explode_q;
    assign o_item = r_item;

    // Priority: map load, then pickup, then flame rise, then lifetime tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_item      <= ITEM_EMPTY;
            r_explode_q <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_explode_q <= i_explode;
            if (i_init_we) begin
                r_item <= i_init_item;
                r_cnt  <= is_visible(i_init_item) ? CNT_W'(LIFETIME) : '0;
            end else if (i_taken) begin
                r_item <= ITEM_EMPTY;
                r_cnt  <= '0;
            end else if (w_rise && is_hidden(r_item)) begin
                r_item <= reveal(r_item);
                r_cnt  <= CNT_W'(LIFETIME);
            end else if (w_rise && is_visible(r_item)) begin
                r_item <= ITEM_EMPTY;
                r_cnt  <= '0;
            end else if (i_tick && is_visible(r_item)) begin
                if (r_cnt <= CNT_W'(1)) begin
                    r_item <= ITEM_EMPTY;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gadget_mgr.sv
// ============================================================================
// Module   : gadget_mgr
// Purpose  : Power-up manager: per-cell items, pickup arbitration, player stats.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gadget_mgr
    import gadget_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int GRID_CELLS  = 256,
    parameter int ADDR_W      = 8,
    parameter int CAP_INIT    = 1,
    parameter int CAP_MAX     = 4,
    parameter int LEN_INIT    = 0,
    parameter int LEN_MAX     = 3,
    parameter int LIFETIME    = 30
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_tick,
    input  logic                                     i_init_we,
    input  logic [ADDR_W-1:0]                        i_init_addr,
    input  logic [CODE_W-1:0]                        i_init_item,
    input  logic [NUM_PLAYERS-1:0][ADDR_W-1:0]       i_player_cor,
    input  logic [NUM_PLAYERS-1:0]                   i_player_alive,
    input  logic [GRID_CELLS-1:0]                    i_explode,
    output logic [NUM_PLAYERS-1:0][2:0]              o_cap,
    output logic [NUM_PLAYERS-1:0][1:0]              o_len,
    output logic [GRID_CELLS-1:0][CODE_W-1:0]        o_gadget_state_grid,
    output logic                                     o_pickup_valid,
    output logic [2:0]                               o_pickup_player,
    output logic [CODE_W-1:0]                        o_pickup_item
);

    logic [GRID_CELLS-1:0][CODE_W-1:0]  w_item;
    logic [GRID_CELLS-1:0]              w_taken;
    logic [NUM_PLAYERS-1:0]             w_collect;
    logic [NUM_PLAYERS-1:0][CODE_W-1:0] w_pitem;
    logic                               w_any;
    logic [2:0]                         w_first;

    logic [NUM_PLAYERS-1:0][2:0]        r_cap;
    logic [NUM_PLAYERS-1:0][1:0]        r_len;
    logic                               r_pickup_valid;
    logic [2:0]                         r_pickup_player;
    logic [CODE_W-1:0]                  r_pickup_item;

    generate
        for (genvar c = 0; c < GRID_CELLS; c++) begin : g_cell
            gadget_cell #(
                .LIFETIME    (LIFETIME)
            ) u_cell (
                .clk         (clk),
                .rst         (rst),
                .i_explode   (i_explode[c]),
                .i_tick      (i_tick),
                .i_taken     (w_taken[c]),
                .i_init_we   (i_init_we && (int'(i_init_addr) == c)),
                .i_init_item (i_init_item),
                .o_item      (w_item[c])
            );
        end
    endgenerate

    // A visible cell is cleared by any alive occupant; only the lowest-index one is credited.
    always_comb begin
        w_taken   = '0;
        w_collect = '0;
        w_pitem   = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (i_player_alive[p] && (int'(i_player_cor[p]) < GRID_CELLS)
                    && is_visible(w_item[i_player_cor[p]])) begin
                w_taken[i_player_cor[p]] = 1'b1;
                w_collect[p]             = 1'b1;
                w_pitem[p]               = w_item[i_player_cor[p]];
                for (int q = 0; q < NUM_PLAYERS; q++) begin
                    if ((q < p) && i_player_alive[q] && (i_player_cor[q] == i_player_cor[p]))
                        w_collect[p] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_any   = |w_collect;
        w_first = '0;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (w_collect[p])
                w_first = 3'(p);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_cap[p] <= 3'(CAP_INIT);
                r_len[p] <= 2'(LEN_INIT);
            end
            r_pickup_valid  <= 1'b0;
            r_pickup_player <= '0;
            r_pickup_item   <= '0;
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (w_collect[p]) begin
                    case (w_pitem[p])
                        ITEM_LOTION: begin
                            if (r_len[p] < 2'(LEN_MAX))
                                r_len[p] <= r_len[p] + 2'd1;
                        end
                        ITEM_ADD_BOMB: begin
                            if (r_cap[p] < 3'(CAP_MAX))
                                r_cap[p] <= r_cap[p] + 3'd1;
                        end
                        ITEM_SKULL: begin
                            r_len[p] <= 2'(LEN_INIT);
                            r_cap[p] <= 3'(CAP_INIT);
                        end
                        default: ;
                    endcase
                end
            end
            r_pickup_valid <= w_any;
            if (w_any) begin
                r_pickup_player <= w_first;
                r_pickup_item   <= w_pitem[w_first];
            end else begin
                r_pickup_player <= '0;
                r_pickup_item   <= '0;
            end
        end
    end

    assign o_cap               = r_cap;
    assign o_len               = r_len;
    assign o_gadget_state_grid = w_item;
    assign o_pickup_valid      = r_pickup_valid;
    assign o_pickup_player     = r_pickup_player;
    assign o_pickup_item       = r_pickup_item;

endmodule

`default_nettype wire

// File: tb/tb_gadget_mgr.sv
// ============================================================================
// Module   : tb_gadget_mgr
// Purpose  : Directed scoreboard bench for gadget_mgr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gadget_mgr;

    localparam int NP = 2;
    localparam int GC = 256;
    localparam int AW = 8;
    localparam int LT = 30;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     tick;
    logic                     init_we;
    logic [AW-1:0]            init_addr;
    logic [2:0]               init_item;
    logic [NP-1:0][AW-1:0]    cor;
    logic [NP-1:0]            alive;
    logic [GC-1:0]            explode;
    logic [NP-1:0][2:0]       cap;
    logic [NP-1:0][1:0]       len;
    logic [GC-1:0][2:0]       grid;
    logic                     pv;
    logic [2:0]               pplayer;
    logic [2:0]               pitem;

    always #5 clk = ~clk;

    gadget_mgr #(
        .NUM_PLAYERS (NP),
        .GRID_CELLS  (GC),
        .ADDR_W      (AW),
        .CAP_INIT    (1),
        .CAP_MAX     (4),
        .LEN_INIT    (0),
        .LEN_MAX     (3),
        .LIFETIME    (LT)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_tick              (tick),
        .i_init_we           (init_we),
        .i_init_addr         (init_addr),
        .i_init_item         (init_item),
        .i_player_cor        (cor),
        .i_player_alive      (alive),
        .i_explode           (explode),
        .o_cap               (cap),
        .o_len               (len),
        .o_gadget_state_grid (grid),
        .o_pickup_valid      (pv),
        .o_pickup_player     (pplayer),
        .o_pickup_item       (pitem)
    );

    typedef struct {
        int p;
        int item;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic expect_ev(input int p, input int item);
        ev_t e;
        e.p    = p;
        e.item = item;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load(input int a, input int it);
        init_we   = 1'b1;
        init_addr = AW'(a);
        init_item = 3'(it);
        cyc();
        init_we   = 1'b0;
    endtask

    task automatic park();
        cor[0] = 8'd200;
        cor[1] = 8'd201;
    endtask

    // Every pickup event the DUT presents is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (!rst && pv) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pickup_unexpected got p=%0d item=%0d want none", pplayer, pitem);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if ((int'(pplayer) != e.p) || (int'(pitem) != e.item)) begin
                    bad++;
                    $display("FAIL pickup_event got p=%0d item=%0d want p=%0d item=%0d",
                             pplayer, pitem, e.p, e.item);
                end
            end
        end
    end

    initial begin
        int exp_len[5];
        exp_len = '{1, 2, 3, 3, 3};

        rst = 1'b1; tick = 1'b0; init_we = 1'b0; init_addr = '0; init_item = '0;
        explode = '0; alive = 2'b11; park();
        cyc(); cyc(); cyc();
        chk("rst_cell4", int'(grid[4]), 0);
        chk("rst_cap0", int'(cap[0]), 1);
        chk("rst_cap1", int'(cap[1]), 1);
        chk("rst_len0", int'(len[0]), 0);
        chk("rst_pv", int'(pv), 0);
        rst = 1'b0;
        cyc();

        // Hidden ADD_BOMB revealed by a held flame: one reveal, no later clearing.
        load(4, 5);
        chk("load_cell4", int'(grid[4]), 5);
        explode[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("hold_cell4", int'(grid[4]), 2);
        end
        explode[4] = 1'b0;
        cyc();

        // Two players on the same cell: only P0 credited.
        cor[0] = 8'd4; cor[1] = 8'd4;
        expect_ev(0, 2);
        cyc();
        park();
        chk("share_cap0", int'(cap[0]), 2);
        chk("share_cap1", int'(cap[1]), 1);
        chk("share_cell4", int'(grid[4]), 0);

        // LOTION saturation then SKULL reset.
        for (int i = 0; i < 5; i++) begin
            load(8, 1);
            cor[0] = 8'd8;
            expect_ev(0, 1);
            cyc();
            park();
            chk("lotion_len0", int'(len[0]), exp_len[i]);
        end
        chk("lotion_cell8", int'(grid[8]), 0);
        load(8, 3);
        cor[0] = 8'd8;
        expect_ev(0, 3);
        cyc();
        park();
        chk("skull_len0", int'(len[0]), 0);
        chk("skull_cap0", int'(cap[0]), 1);

        // Lifetime expiry: survives 29 ticks, gone on the 30th, no event.
        load(19, 4);
        explode[19] = 1'b1;
        cyc();
        explode[19] = 1'b0;
        chk("reveal_cell19", int'(grid[19]), 1);
        for (int k = 0; k < LT - 1; k++) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc();
        end
        chk("life29_cell19", int'(grid[19]), 1);
        tick = 1'b1; cyc();
        tick = 1'b0;
        chk("life30_cell19", int'(grid[19]), 0);
        cyc();

        // Pickup beats a simultaneous flame rise.
        load(28, 1);
        explode[28] = 1'b1;
        cor[1] = 8'd28;
        expect_ev(1, 1);
        cyc();
        explode[28] = 1'b0;
        park();
        chk("prio_len1", int'(len[1]), 1);
        chk("prio_cell28", int'(grid[28]), 0);

        // Map load beats a simultaneous flame rise; next separate rise reveals.
        explode[10] = 1'b1;
        load(10, 5);
        chk("initwin_cell10", int'(grid[10]), 5);
        explode[10] = 1'b0;
        cyc();
        explode[10] = 1'b1;
        cyc();
        explode[10] = 1'b0;
        chk("rerise_cell10", int'(grid[10]), 2);

        // Dead player collects nothing.
        load(30, 2);
        cor[0] = 8'd30; alive = 2'b10;
        cyc();
        chk("dead_cell30", int'(grid[30]), 2);
        chk("dead_cap0", int'(cap[0]), 1);
        alive = 2'b11; park();
        cyc();

        // Players on different cells collect together; P0 is reported.
        load(40, 1);
        load(41, 2);
        cor[0] = 8'd40; cor[1] = 8'd41;
        expect_ev(0, 1);
        cyc();
        park();
        chk("dual_len0", int'(len[0]), 1);
        chk("dual_cap1", int'(cap[1]), 2);
        chk("dual_cell40", int'(grid[40]), 0);
        chk("dual_cell41", int'(grid[41]), 0);

        cyc(); cyc(); cyc();
        chk("events_outstanding", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
